// File: rtl/step_sched_pkg.sv
// ============================================================================
// step_sched_pkg : shared types for the step pulse scheduler
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package step_sched_pkg;

  localparam int STEP_W_DEF     = 16;
  localparam int DIV_W_DEF      = 12;
  localparam int MIN_PERIOD_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic                 dir;
    logic [STEP_W_DEF-1:0] steps;
    logic [DIV_W_DEF-1:0]  period;
  } step_cmd_t;

endpackage

`default_nettype wire

// File: rtl/step_sched_timer.sv
// ============================================================================
// step_sched_timer : period down-counter, one-cycle tick every loaded period
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module step_sched_timer #(
  parameter int DIV_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] period,
  input  logic             en,
  output logic             tick
);

  logic [DIV_W-1:0] r_count;
  logic [DIV_W-1:0] r_reload;

  assign tick = en && (r_count == DIV_W'(1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_reload <= '0;
    end else if (load) begin
      r_count  <= period;
      r_reload <= period;
    end else if (tick) begin
      r_count  <= r_reload;
    end else if (en && (r_count != '0)) begin
      r_count  <= r_count - 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/step_pulse_sched.sv
// ============================================================================
// step_pulse_sched : move scheduler emitting plus/minus step pulses at a
// programmed rate. Optional one-entry command buffer: STEP_SCHED_QUEUE_EN.
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module step_pulse_sched
  import step_sched_pkg::*;
#(
  parameter int STEP_W     = STEP_W_DEF,
  parameter int DIV_W      = DIV_W_DEF,
  parameter int MIN_PERIOD = MIN_PERIOD_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic [DIV_W-1:0]  cmd_period,
  input  logic              abort,
  output logic              plus,
  output logic              minus,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] steps_left
);

  state_t            r_state;
  state_t            w_state_nx;
  logic              r_dir;
  logic [STEP_W-1:0] r_steps_left;
  logic              r_plus;
  logic              r_minus;

  logic              w_accept;
  logic              w_start;
  logic              w_start_dir;
  logic [STEP_W-1:0] w_start_steps;
  logic [DIV_W-1:0]  w_start_period;
  logic [DIV_W-1:0]  w_period_eff;
  logic              w_tick;
  logic              w_tmr_en;

`ifdef STEP_SCHED_QUEUE_EN
  typedef struct packed {
    logic              dir;
    logic [STEP_W-1:0] steps;
    logic [DIV_W-1:0]  period;
  } buf_cmd_t;

  logic     r_buf_valid;
  buf_cmd_t r_buf;

  assign cmd_ready = rst_n & ((r_state == ST_IDLE) | ~r_buf_valid);
  assign w_accept  = cmd_valid & cmd_ready;
  // A buffered command takes priority when leaving DONE; an empty buffer lets
  // a command arriving in DONE start directly.
  assign w_start   = ((r_state == ST_IDLE) & w_accept) |
                     ((r_state == ST_DONE) & (r_buf_valid | w_accept));
  assign w_start_dir    = r_buf_valid ? r_buf.dir    : cmd_dir;
  assign w_start_steps  = r_buf_valid ? r_buf.steps  : cmd_steps;
  assign w_start_period = r_buf_valid ? r_buf.period : cmd_period;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_buf_valid <= 1'b0;
      r_buf       <= '0;
    end else if ((r_state == ST_RUN) && abort) begin
      r_buf_valid <= 1'b0;
    end else if ((r_state == ST_DONE) && r_buf_valid) begin
      r_buf_valid <= 1'b0;
    end else if ((r_state == ST_RUN) && w_accept) begin
      r_buf_valid <= 1'b1;
      r_buf       <= '{dir: cmd_dir, steps: cmd_steps, period: cmd_period};
    end
  end
`else
  assign cmd_ready      = rst_n & (r_state == ST_IDLE);
  assign w_accept       = cmd_valid & cmd_ready;
  assign w_start        = w_accept;
  assign w_start_dir    = cmd_dir;
  assign w_start_steps  = cmd_steps;
  assign w_start_period = cmd_period;
`endif

  assign w_period_eff = (w_start_period < DIV_W'(MIN_PERIOD)) ? DIV_W'(MIN_PERIOD)
                                                              : w_start_period;
  assign w_tmr_en     = (r_state == ST_RUN) && (r_steps_left != '0);

  step_sched_timer #(
    .DIV_W (DIV_W)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (w_start),
    .period (w_period_eff),
    .en     (w_tmr_en),
    .tick   (w_tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nx;
  end

  // A zero-step move still passes through RUN for one cycle before DONE.
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_state_nx = ST_RUN;
      ST_RUN:  if (abort || (r_steps_left == '0)) w_state_nx = ST_DONE;
      ST_DONE: w_state_nx = w_start ? ST_RUN : ST_IDLE;
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dir        <= 1'b0;
      r_steps_left <= '0;
      r_plus       <= 1'b0;
      r_minus      <= 1'b0;
    end else begin
      r_plus  <= 1'b0;
      r_minus <= 1'b0;
      if (w_start) begin
        r_dir        <= w_start_dir;
        r_steps_left <= w_start_steps;
      end else if (w_tick && !abort) begin
        r_steps_left <= r_steps_left - 1'b1;
        r_plus       <= r_dir;
        r_minus      <= ~r_dir;
      end
    end
  end

  assign plus       = r_plus;
  assign minus      = r_minus;
  assign busy       = (r_state != ST_IDLE);
  assign done       = (r_state == ST_DONE);
  assign steps_left = r_steps_left;

endmodule

`default_nettype wire

// File: tb/tb_step_pulse_sched.sv
// ============================================================================
// tb_step_pulse_sched : self-checking bench for step_pulse_sched
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_step_pulse_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_dir = 1'b0;
  logic [15:0] cmd_steps = '0;
  logic [11:0] cmd_period = '0;
  logic        abort = 1'b0;
  logic        plus;
  logic        minus;
  logic        busy;
  logic        done;
  logic [15:0] steps_left;

  int errors = 0;
  int checks = 0;

  step_pulse_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dir    (cmd_dir),
    .cmd_steps  (cmd_steps),
    .cmd_period (cmd_period),
    .abort      (abort),
    .plus       (plus),
    .minus      (minus),
    .busy       (busy),
    .done       (done),
    .steps_left (steps_left)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick_edge();
    tick_edge();
    checks++;
    if ({plus, minus, busy, done, cmd_ready} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got=%b exp=00000", {plus, minus, busy, done, cmd_ready});
    end
    checks++;
    if (steps_left !== 16'd0) begin
      errors++;
      $display("FAIL reset_steps_left got=%0d exp=0", steps_left);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got=%b exp=1", cmd_ready);
    end
  endtask

  // Expected outputs after edge n (n=0 is the accept edge) are derived from the
  // schedule: pulse k lands on n=k*P, done follows the last pulse or the abort.
  task automatic test_move(input string name, input logic d, input int s, input int p,
                           input int abort_k, input bit keep_valid,
                           input logic hd, input int hs, input int hp);
    int pe, end_n, pulses, wait_cnt;
    logic pulse_now;
    logic [4:0] got, exp;
    pe    = (p < 2) ? 2 : p;
    end_n = (abort_k > 0) ? abort_k * pe : s * pe + 1;
    cmd_valid  = 1'b1;
    cmd_dir    = d;
    cmd_steps  = 16'(s);
    cmd_period = 12'(p);
    wait_cnt = 0;
    while (cmd_ready !== 1'b1 && wait_cnt < 20) begin
      tick_edge();
      wait_cnt++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s accept_timeout ready=%b exp=1", name, cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    tick_edge();
    if (keep_valid) begin
      cmd_dir    = hd;
      cmd_steps  = 16'(hs);
      cmd_period = 12'(hp);
    end else begin
      cmd_valid = 1'b0;
    end
    for (int n = 0; n <= end_n + 1; n++) begin
      if (n > 0) begin
        abort = (abort_k > 0) && (n == end_n);
        tick_edge();
        abort = 1'b0;
      end
      pulse_now = (n > 0) && (n % pe == 0) && (n / pe <= s) &&
                  !((abort_k > 0) && (n / pe >= abort_k));
      pulses = n / pe;
      if (pulses > s) pulses = s;
      if (abort_k > 0 && pulses > abort_k - 1) pulses = abort_k - 1;
      exp = {pulse_now && d, pulse_now && !d, n <= end_n, n == end_n, n > end_n};
      got = {plus, minus, busy, done, cmd_ready};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL %s flags(plus,minus,busy,done,ready) n=%0d got=%b exp=%b",
                 name, n, got, exp);
      end
      checks++;
      if (steps_left !== 16'(s - pulses)) begin
        errors++;
        $display("FAIL %s steps_left n=%0d got=%0d exp=%0d", name, n, steps_left, s - pulses);
      end
    end
  endtask

  task automatic test_back_to_back_hold();
    // Second command is presented throughout the first move and must wait.
    test_move("hold_a", 1'b1, 2, 3, 0, 1'b1, 1'b0, 3, 2);
    test_move("hold_b", 1'b0, 3, 2, 0, 1'b0, 1'b0, 0, 0);
  endtask

  task automatic test_abort_idle();
    abort = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick_edge();
      checks++;
      if ({busy, done, plus, minus, cmd_ready} !== 5'b00001) begin
        errors++;
        $display("FAIL abort_idle i=%0d got=%b exp=00001", i, {busy, done, plus, minus, cmd_ready});
      end
    end
    abort = 1'b0;
  endtask

  task automatic test_reset_mid_move();
    bit saw;
    cmd_valid  = 1'b1;
    cmd_dir    = 1'b1;
    cmd_steps  = 16'd5;
    cmd_period = 12'd3;
    tick_edge();
    cmd_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick_edge();
    checks++;
    if (busy !== 1'b1 || steps_left !== 16'd3) begin
      errors++;
      $display("FAIL reset_mid_pre busy=%b left=%0d exp busy=1 left=3", busy, steps_left);
    end
    rst_n = 1'b0;
    tick_edge();
    checks++;
    if ({plus, minus, busy, done, cmd_ready} !== 5'b0 || steps_left !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid flags=%b left=%0d exp flags=00000 left=0",
               {plus, minus, busy, done, cmd_ready}, steps_left);
    end
    rst_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick_edge();
      if (done || busy || plus || minus) saw = 1'b1;
    end
    checks++;
    if (saw !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_after activity_seen=%b exp=0", saw);
    end
  endtask

  task automatic test_random();
    int s, p, ak;
    logic d;
    for (int i = 0; i < 12; i++) begin
      d  = 1'($urandom % 2);
      s  = int'($urandom_range(0, 6));
      p  = int'($urandom_range(0, 6));
      ak = (s > 0 && ($urandom % 3) == 0) ? int'($urandom_range(1, s)) : 0;
      test_move("random", d, s, p, ak, 1'b0, 1'b0, 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_move("plus3_p4",   1'b1, 3,  4,    0, 1'b0, 1'b0, 0, 0);
    test_move("clamp_p0",   1'b0, 2,  0,    0, 1'b0, 1'b0, 0, 0);
    test_move("zero_steps", 1'b0, 0,  7,    0, 1'b0, 1'b0, 0, 0);
    test_move("abort_5",    1'b1, 10, 3,    5, 1'b0, 1'b0, 0, 0);
    test_move("clamp_p1",   1'b1, 2,  1,    0, 1'b0, 1'b0, 0, 0);
    test_move("max_period", 1'b0, 1,  4095, 0, 1'b0, 1'b0, 0, 0);
    test_move("abort_1",    1'b0, 4,  2,    1, 1'b0, 1'b0, 0, 0);
    test_back_to_back_hold();
    test_abort_idle();
    test_reset_mid_move();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
